// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache:
// FSM state encodings, response payload, memory-side widths and
// address field-split helpers (tag / index / word / line base).
package instruction_cache_pkg;

    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned INSTR_W        = 32;
    localparam int unsigned MEM_DATA_W     = 8;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ICACHE_IDLE    = 2'd0,
        ICACHE_REFILL  = 2'd1,
        ICACHE_RESPOND = 2'd2
    } icache_state_e;

    // Registered response payload returned to the instruction unit.
    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] instr;
    } icache_resp_t;

    // Tag field: everything above offset and index.
    function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] a,
                                                   input int unsigned off,
                                                   input int unsigned idx);
        return a >> (off + idx);
    endfunction

    // Line index field.
    function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] a,
                                                     input int unsigned off,
                                                     input int unsigned idx);
        return (a >> off) & ((32'd1 << idx) - 32'd1);
    endfunction

    // Word-within-line field.
    function automatic logic [ADDR_W-1:0] addr_word(input logic [ADDR_W-1:0] a,
                                                    input int unsigned off);
        return (a >> 2) & ((32'd1 << (off - 2)) - 32'd1);
    endfunction

    // Byte address of the first byte in the line.
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a,
                                                    input int unsigned off);
        return a & ~((32'd1 << off) - 32'd1);
    endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// Fetch + memory-read bus of the instruction cache.
//   fetch side : flushIn, reqValid, reqAddr -> instrOutValid, instrOut, instrAddrOut
//   memory side: memRequest, memAddr -> memGrant, memDataIn (byte one cycle after grant)
// slave  : the cache view
// master : the instruction unit / memory controller view
interface instruction_cache_if;
    import instruction_cache_pkg::*;

    logic                  flushIn;
    logic                  reqValid;
    logic [ADDR_W-1:0]     reqAddr;
    logic                  instrOutValid;
    logic [INSTR_W-1:0]    instrOut;
    logic [ADDR_W-1:0]     instrAddrOut;
    logic                  memRequest;
    logic [ADDR_W-1:0]     memAddr;
    logic                  memGrant;
    logic [MEM_DATA_W-1:0] memDataIn;

    modport slave (
        input  flushIn, reqValid, reqAddr, memGrant, memDataIn,
        output instrOutValid, instrOut, instrAddrOut, memRequest, memAddr
    );

    modport master (
        output flushIn, reqValid, reqAddr, memGrant, memDataIn,
        input  instrOutValid, instrOut, instrAddrOut, memRequest, memAddr
    );

endinterface

// File: rtl/instruction_cache_refill_engine.sv
// Line refill engine: issues the byte reads of one cache line over the
// arbitrated memory port, captures each returned byte one cycle after its
// grant and assembles little-endian words for the data array.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start_c, base_addr      begin refill of the line at base_addr
//   mem_grant, mem_data     controller grant / returned byte
//   mem_request, mem_addr   registered read request and byte address
//   word_we_c/idx_c/data_c  completed word write into the line
//   line_done_c             last byte of the line is being captured
module instruction_cache_refill_engine
    import instruction_cache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_c,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic                  mem_grant,
    input  logic [MEM_DATA_W-1:0] mem_data,
    output logic                  mem_request,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  word_we_c,
    output logic [((LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1)-1:0] word_idx_c,
    output logic [INSTR_W-1:0]    word_data_c,
    output logic                  line_done_c
);

    localparam int unsigned LINE_BYTES = LINE_WORDS * BYTES_PER_WORD;
    localparam int unsigned CNT_W      = $clog2(LINE_BYTES) + 1;
    localparam int unsigned WORD_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    logic [CNT_W-1:0]  issue_q, issue_d;
    logic [CNT_W-1:0]  recv_q, recv_d;
    logic              rx_pending_q, rx_pending_d;
    logic [23:0]       asm_q, asm_d;
    logic              mem_request_q, mem_request_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ADDR_W-1:0] base_q, base_d;

    // Issue/receive bookkeeping and word assembly.
    always_comb begin
        issue_d       = issue_q;
        recv_d        = recv_q;
        rx_pending_d  = mem_request_q & mem_grant;
        asm_d         = asm_q;
        mem_request_d = mem_request_q;
        mem_addr_d    = mem_addr_q;
        base_d        = base_q;
        word_we_c     = 1'b0;
        word_idx_c    = WORD_W'(recv_q >> 2);
        word_data_c   = {mem_data, asm_q};
        line_done_c   = 1'b0;

        if (mem_request_q && mem_grant) begin
            issue_d = issue_q + CNT_W'(1);
            if (issue_d == CNT_W'(LINE_BYTES)) begin
                mem_request_d = 1'b0;    // address holds on the last byte
            end else begin
                mem_addr_d = base_q + ADDR_W'(issue_d);
            end
        end

        // Bytes arrive lowest first; shift in from the top so byte 0 ends at [7:0].
        if (rx_pending_q) begin
            recv_d = recv_q + CNT_W'(1);
            asm_d  = {mem_data, asm_q[23:8]};
            if (recv_q[1:0] == 2'd3) begin
                word_we_c = 1'b1;
            end
            if (recv_q == CNT_W'(LINE_BYTES - 1)) begin
                line_done_c = 1'b1;
            end
        end

        if (start_c) begin
            issue_d       = '0;
            recv_d        = '0;
            rx_pending_d  = 1'b0;
            mem_request_d = 1'b1;
            mem_addr_d    = base_addr;
            base_d        = base_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_q       <= '0;
            recv_q        <= '0;
            rx_pending_q  <= 1'b0;
            asm_q         <= '0;
            mem_request_q <= 1'b0;
            mem_addr_q    <= '0;
            base_q        <= '0;
        end else begin
            issue_q       <= issue_d;
            recv_q        <= recv_d;
            rx_pending_q  <= rx_pending_d;
            asm_q         <= asm_d;
            mem_request_q <= mem_request_d;
            mem_addr_q    <= mem_addr_d;
            base_q        <= base_d;
        end
    end

    assign mem_request = mem_request_q;
    assign mem_addr    = mem_addr_q;

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache. Hits answer one cycle after
// the request is sampled; misses refill the whole line byte by byte and
// then answer. A flush drops any response still owed.
// Ports:
//   clockIn, resetIn     clock, async active-low reset
//   bus (slave)          fetch request/response and memory read port
//   hitCount, missCount  request counters, present only with ICACHE_STATS_EN
// Optional feature macro: ICACHE_STATS_EN
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int unsigned LINES      = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                clockIn,
    input  logic                resetIn,
    instruction_cache_if.slave  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]         hitCount,
    output logic [31:0]         missCount
`endif
);

    localparam int unsigned OFF    = $clog2(LINE_WORDS * BYTES_PER_WORD);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned TAG_W  = ADDR_W - OFF - IDX_W;
    localparam int unsigned WORD_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    icache_state_e      state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [INSTR_W-1:0] data_q [LINES][LINE_WORDS];
    logic [ADDR_W-1:0]  miss_addr_q, miss_addr_d;
    logic               drop_q, drop_d;
    logic               out_valid_q, out_valid_d;
    icache_resp_t       resp_q, resp_d;

    logic [IDX_W-1:0]   req_idx_c, miss_idx_c;
    logic [WORD_W-1:0]  req_word_c, miss_word_c;
    logic [TAG_W-1:0]   req_tag_c, miss_tag_c;
    logic [ADDR_W-1:0]  line_base_c;
    logic               sample_c, hit_c;
    logic               start_c, hit_evt_c, miss_evt_c;
    logic [INSTR_W-1:0] fill_word_c;

    logic               mem_request;
    logic [ADDR_W-1:0]  mem_addr;
    logic               word_we_c, line_done_c;
    logic [WORD_W-1:0]  word_idx_c;
    logic [INSTR_W-1:0] word_data_c;

    // Address split of the incoming request and of the latched miss.
    always_comb begin
        req_idx_c   = IDX_W'(addr_index(bus.reqAddr, OFF, IDX_W));
        req_word_c  = WORD_W'(addr_word(bus.reqAddr, OFF));
        req_tag_c   = TAG_W'(addr_tag(bus.reqAddr, OFF, IDX_W));
        line_base_c = line_base(bus.reqAddr, OFF);
        miss_idx_c  = IDX_W'(addr_index(miss_addr_q, OFF, IDX_W));
        miss_word_c = WORD_W'(addr_word(miss_addr_q, OFF));
        miss_tag_c  = TAG_W'(addr_tag(miss_addr_q, OFF, IDX_W));
    end

    // Sampling is blocked while a response pulse is out (duplicate guard).
    assign sample_c = (state_q == ICACHE_IDLE) && bus.reqValid && !out_valid_q;
    assign hit_c    = valid_q[req_idx_c] && (tag_q[req_idx_c] == req_tag_c);

    // The requested word may be the one completing in this very cycle.
    assign fill_word_c = (word_we_c && (word_idx_c == miss_word_c)) ?
                         word_data_c : data_q[miss_idx_c][miss_word_c];

    instruction_cache_refill_engine #(
        .LINE_WORDS (LINE_WORDS)
    ) u_refill (
        .clk         (clockIn),
        .rst_n       (resetIn),
        .start_c     (start_c),
        .base_addr   (line_base_c),
        .mem_grant   (bus.memGrant),
        .mem_data    (bus.memDataIn),
        .mem_request (mem_request),
        .mem_addr    (mem_addr),
        .word_we_c   (word_we_c),
        .word_idx_c  (word_idx_c),
        .word_data_c (word_data_c),
        .line_done_c (line_done_c)
    );

    // Next-state and response logic.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        miss_addr_d = miss_addr_q;
        drop_d      = drop_q;
        out_valid_d = 1'b0;
        resp_d      = resp_q;
        start_c     = 1'b0;
        hit_evt_c   = 1'b0;
        miss_evt_c  = 1'b0;

        unique case (state_q)
            ICACHE_IDLE: begin
                if (sample_c) begin
                    if (hit_c) begin
                        hit_evt_c = 1'b1;
                        if (!bus.flushIn) begin
                            out_valid_d  = 1'b1;
                            resp_d.addr  = bus.reqAddr;
                            resp_d.instr = data_q[req_idx_c][req_word_c];
                        end
                    end else begin
                        miss_evt_c           = 1'b1;
                        miss_addr_d          = bus.reqAddr;
                        drop_d               = bus.flushIn;
                        valid_d[req_idx_c]   = 1'b0;   // line is about to be overwritten
                        start_c              = 1'b1;
                        state_d              = ICACHE_REFILL;
                    end
                end
            end
            ICACHE_REFILL: begin
                if (bus.flushIn) begin
                    drop_d = 1'b1;
                end
                if (line_done_c) begin
                    valid_d[miss_idx_c] = 1'b1;
                    if (drop_q || bus.flushIn) begin
                        drop_d  = 1'b0;
                        state_d = ICACHE_IDLE;
                    end else begin
                        out_valid_d  = 1'b1;
                        resp_d.addr  = miss_addr_q;
                        resp_d.instr = fill_word_c;
                        state_d      = ICACHE_RESPOND;
                    end
                end
            end
            ICACHE_RESPOND: begin
                state_d = ICACHE_IDLE;   // pulse is on the output this cycle
            end
            default: begin
                state_d = ICACHE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            state_q     <= ICACHE_IDLE;
            valid_q     <= '0;
            miss_addr_q <= '0;
            drop_q      <= 1'b0;
            out_valid_q <= 1'b0;
            resp_q      <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            miss_addr_q <= miss_addr_d;
            drop_q      <= drop_d;
            out_valid_q <= out_valid_d;
            resp_q      <= resp_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate them.
    always_ff @(posedge clockIn) begin
        if ((state_q == ICACHE_REFILL) && line_done_c) begin
            tag_q[miss_idx_c] <= miss_tag_c;
        end
        if (word_we_c) begin
            data_q[miss_idx_c][word_idx_c] <= word_data_c;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    // Per sampled request, flushed ones included; wraps naturally.
    always_comb begin
        hit_count_d  = hit_count_q + 32'(hit_evt_c);
        miss_count_d = miss_count_q + 32'(miss_evt_c);
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hitCount  = hit_count_q;
    assign missCount = miss_count_q;
`else
    logic stats_unused_c;
    assign stats_unused_c = hit_evt_c ^ miss_evt_c;
`endif

    assign bus.instrOutValid = out_valid_q;
    assign bus.instrOut      = resp_q.instr;
    assign bus.instrAddrOut  = resp_q.addr;
    assign bus.memRequest    = mem_request;
    assign bus.memAddr       = mem_addr;

endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache between the instruction unit's PC request port and the byte-wide memory controller.
- Accepts a fetch request (valid + PC). Returns the 32-bit instruction word and its address as a one-cycle valid pulse.
- On a miss, refills a whole line byte by byte over the arbitrated memory read port.

Parameters:
- LINES, 16: number of lines (power of 2, 2..256).
- LINE_WORDS, 4: 32-bit words per line (power of 2, 1..16).
- Derived: OFF = log2(LINE_WORDS*4); IDX = log2(LINES); tag = addr[31:OFF+IDX]; index = addr[OFF+IDX-1:OFF]; word = addr[OFF-1:2].

Ports:
- clockIn  in  1  system clock.
- resetIn  in  1  reset.
- flushIn  in  1  mispredict/redirect; drop any response owed.
- reqValid  in  1  fetch request (instruction unit instrOutValid).
- reqAddr  in  32  fetch PC; bits [1:0] ignored.
- instrOutValid  out  1  response valid, one-cycle pulse.
- instrOut  out  32  instruction word, little-endian.
- instrAddrOut  out  32  PC the response belongs to.
- memRequest  out  1  read request to memory controller.
- memAddr  out  32  byte address being read.
- memGrant  in  1  controller accepted memAddr this cycle.
- memDataIn  in  8  byte for the address granted in the previous cycle.

Interface decision: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (resetIn low, asynchronous): state IDLE; all valid bits 0; instrOutValid=0, instrOut=0, instrAddrOut=0, memRequest=0, memAddr=0; counters 0. Tag/data arrays are not reset.
- IDLE: samples reqValid/reqAddr at the clock edge only when instrOutValid is currently 0. This one-cycle cooldown prevents a duplicate response while the requester updates its PC. Peak throughput is one response per 2 cycles.
- Hit (valid[index] and tag match): next cycle drives instrOutValid=1 with instrOut=data[index][word] and instrAddrOut=reqAddr. Hit latency is 1 cycle. Stays in IDLE.
- Miss: latch reqAddr, go to REFILL.
- REFILL:
  - memRequest=1; memAddr = line base + issue count.
  - Each cycle with memGrant=1 increments the issue count.
  - The byte returns on memDataIn the next cycle and is written to line byte (receive count), little-endian within each word.
  - When memGrant drops, issuing pauses and memAddr holds. The one outstanding byte is still captured.
  - memRequest deasserts in the cycle after the last byte is issued (issue count = LINE_WORDS*4).
  - When the last byte is received: set valid[index], write the tag, go to RESPOND.
- RESPOND: one cycle; drives instrOutValid=1 with the requested word and address, then returns to IDLE.
- Miss latency with continuous grant, LINE_WORDS=4: request sampled at edge 0, bytes issued at edges 1..16, last byte received edge 17, instrOutValid high in cycle 18.
- flushIn=1 in IDLE: the hit response scheduled for the next cycle is suppressed.
- flushIn=1 in REFILL: sets a drop flag. The refill still completes and the line is installed (memory traffic is never abandoned mid-line). RESPOND is then skipped and the FSM goes straight to IDLE.
- flushIn=1 in the same cycle instrOutValid is high: that pulse is already registered and still appears; the instruction unit discards it.
- Reqs arriving in REFILL/RESPOND are ignored. The requester holds its PC, so it is re-sampled in IDLE.
- No self-modifying-code coherence: memory writes never invalidate lines.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined: adds output ports hitCount[31:0] and missCount[31:0].
  - They increment once per sampled request that is a hit or a miss, including requests later dropped by flush.
  - They wrap modulo 2^32 and reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package (e.g. cpu_defs): ICACHE_IDLE/REFILL/RESPOND state encodings, the address field-split helpers, and the memory-request width constants.
- One natural sub-module, icache_refill_engine: issue/receive counters, memRequest/memAddr generation, byte-to-word assembly. It signals lineDone to the top-level FSM.

Test Plan:
- Cold miss then hit: reset, request 0x00000000 with continuous grant, memory byte k = k → instrOutValid in cycle 18, instrOut=0x03020100. Re-request 0x4 → 1-cycle hit with 0x07060504, no memRequest.
- Grant stalls: memGrant low on alternate cycles during refill of 0x100 → all 16 bytes correct, memAddr sequence 0x100..0x10F with no skips or repeats.
- Conflict eviction: fill 0x000, then request 0x100 (same index, different tag) → miss and refill. Re-request 0x000 → miss again.
- Flush mid-refill: flushIn pulse at refill cycle 5 → no instrOutValid, line still installed. Subsequent request to the same PC hits in 1 cycle.
- Held request: reqValid held high with constant PC 0x8 after a hit → responses alternate high/low every other cycle, never two consecutive valid cycles.
- Async reset mid-REFILL: resetIn low → memRequest=0 and instrOutValid=0 immediately. A later request to the same line misses.
